// File: rtl/inst_fetch_pkg.sv
// Shared widths, constants and IF-stage state encodings for the naive-mips fetch stage.
package inst_fetch_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    IfFetch = 2'd0,
    IfHold  = 2'd1,
    IfDrain = 2'd2
  } if_state_e;

endpackage

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake to instruction memory,
// and holds one skid entry so a response landing during a stall is never lost.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = ZeroWord
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_flag,
  input  logic [InstAddrBus-1:0] branch_target,
  output logic                   inst_req,
  output logic [InstAddrBus-1:0] inst_addr,
  input  logic                   inst_ack,
  input  logic [InstBus-1:0]     inst_rdata,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst,
  output logic                   if_valid
);

  if_state_e              st_q, st_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic [InstAddrBus-1:0] req_addr_q, req_addr_d;
  logic                   out_q, out_d;
  logic                   kill_q, kill_d;
  logic [InstAddrBus-1:0] if_pc_q, if_pc_d;
  logic [InstBus-1:0]     if_inst_q, if_inst_d;
  logic                   if_valid_q, if_valid_d;
  logic [InstAddrBus-1:0] sk_pc_q, sk_pc_d;
  logic [InstBus-1:0]     sk_inst_q, sk_inst_d;
  logic                   sk_valid_q, sk_valid_d;

  always_comb begin
    st_d       = st_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    sk_pc_d    = sk_pc_q;
    sk_inst_d  = sk_inst_q;
    sk_valid_d = sk_valid_q;
    inst_req   = 1'b0;
    // While draining, the abandoned request's address must stay on the bus until its ack.
    inst_addr  = kill_q ? req_addr_q : pc_q;

    unique case (st_q)
      IfFetch: begin
        inst_req = out_q | (~stall & ~sk_valid_q);
        if (stall) begin
          if (inst_ack) begin
            sk_pc_d    = inst_addr;
            sk_inst_d  = inst_rdata;
            sk_valid_d = 1'b1;
            pc_d       = inst_addr + 32'd4;
            st_d       = IfHold;
          end
        end else begin
          if_pc_d    = ZeroWord;
          if_inst_d  = ZeroWord;
          if_valid_d = 1'b0;
          if (branch_flag) begin
            // Delay slot already went down the pipe; the sequential fetch is squashed.
            pc_d = branch_target;
            if (inst_req && !inst_ack) begin
              kill_d = 1'b1;
              st_d   = IfDrain;
            end
          end else if (inst_ack) begin
            if_pc_d    = inst_addr;
            if_inst_d  = inst_rdata;
            if_valid_d = 1'b1;
            pc_d       = inst_addr + 32'd4;
          end
        end
      end
      IfHold: begin
        if (!stall) begin
          if (branch_flag) begin
            pc_d       = branch_target;
            if_pc_d    = ZeroWord;
            if_inst_d  = ZeroWord;
            if_valid_d = 1'b0;
          end else begin
            if_pc_d    = sk_pc_q;
            if_inst_d  = sk_inst_q;
            if_valid_d = sk_valid_q;
          end
          sk_valid_d = 1'b0;
          st_d       = IfFetch;
        end
      end
      IfDrain: begin
        inst_req = 1'b1;
        if (!stall) begin
          if_pc_d    = ZeroWord;
          if_inst_d  = ZeroWord;
          if_valid_d = 1'b0;
          if (branch_flag) pc_d = branch_target;
        end
        if (inst_ack) begin
          kill_d = 1'b0;
          st_d   = IfFetch;
        end
      end
      default: st_d = IfFetch;
    endcase

    if (rst) inst_req = 1'b0;
  end

  assign out_d      = inst_req & ~inst_ack;
  assign req_addr_d = inst_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= IfFetch;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      out_q      <= 1'b0;
      kill_q     <= 1'b0;
      if_pc_q    <= ZeroWord;
      if_inst_q  <= ZeroWord;
      if_valid_q <= 1'b0;
      sk_pc_q    <= ZeroWord;
      sk_inst_q  <= ZeroWord;
      sk_valid_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      out_q      <= out_d;
      kill_q     <= kill_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      sk_pc_q    <= sk_pc_d;
      sk_inst_q  <= sk_inst_d;
      sk_valid_q <= sk_valid_d;
    end
  end

  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;
  assign if_valid = if_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: each scenario task drives vectors and checks hand-computed values.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int checks;
  int failures;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_ack     (inst_ack),
    .inst_rdata   (inst_rdata),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_valid     (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; one-shot strobes fall back to idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    branch_flag = 1'b0;
    inst_ack    = 1'b0;
    inst_rdata  = 32'h0;
  endtask

  // Leaves the bench at the start of the first cycle with rst low.
  task automatic do_reset();
    rst           = 1'b1;
    stall         = 1'b0;
    branch_flag   = 1'b0;
    branch_target = 32'h0;
    inst_ack      = 1'b0;
    inst_rdata    = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'h0;
    inst_ack = 1'b0; inst_rdata = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (inst_req !== 1'b0) begin
      failures++; $display("FAIL reset_req got=%b want=0", inst_req);
    end
    checks++;
    if (inst_addr !== 32'h0) begin
      failures++; $display("FAIL reset_addr got=%h want=00000000", inst_addr);
    end
    checks++;
    if ({if_valid, if_pc, if_inst} !== 65'h0) begin
      failures++; $display("FAIL reset_slot got=%b/%h/%h want=0/0/0", if_valid, if_pc, if_inst);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h0) begin
      failures++; $display("FAIL reset_first_req got=%b/%h want=1/00000000", inst_req, inst_addr);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      inst_ack   = 1'b1;
      inst_rdata = 32'(i * 4);
      #1;
      checks++;
      if (inst_req !== 1'b1 || inst_addr !== 32'(i * 4)) begin
        failures++;
        $display("FAIL zw_req[%0d] got=%b/%h want=1/%h", i, inst_req, inst_addr, 32'(i * 4));
      end
      if (i > 0) begin
        checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 32'((i - 1) * 4), 32'((i - 1) * 4)}) begin
          failures++;
          $display("FAIL zw_slot[%0d] got=%b/%h/%h want=1/%h/%h", i, if_valid, if_pc, if_inst,
                   32'((i - 1) * 4), 32'((i - 1) * 4));
        end
      end
      cyc();
    end
  endtask

  task automatic test_latency();
    do_reset();
    #1;
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h0 || if_valid !== 1'b0) begin
      failures++; $display("FAIL lat_c0 got=%b/%h/%b want=1/00000000/0", inst_req, inst_addr, if_valid);
    end
    cyc();
    inst_ack = 1'b1; inst_rdata = 32'h1111_0000;
    #1;
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h0) begin
      failures++; $display("FAIL lat_hold got=%b/%h want=1/00000000", inst_req, inst_addr);
    end
    cyc();
    #1;
    checks++;
    if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h0, 32'h1111_0000} || inst_addr !== 32'h4) begin
      failures++;
      $display("FAIL lat_first got=%b/%h/%h addr=%h want=1/00000000/11110000 addr=00000004",
               if_valid, if_pc, if_inst, inst_addr);
    end
    cyc();
    inst_ack = 1'b1; inst_rdata = 32'h2222_0004;
    #1;
    checks++;
    if ({if_valid, if_inst} !== 33'h0 || inst_addr !== 32'h4 || inst_req !== 1'b1) begin
      failures++;
      $display("FAIL lat_bubble got=%b/%h addr=%h want=0/00000000 addr=00000004",
               if_valid, if_inst, inst_addr);
    end
    cyc();
    #1;
    checks++;
    if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h4, 32'h2222_0004}) begin
      failures++;
      $display("FAIL lat_second got=%b/%h/%h want=1/00000004/22220004", if_valid, if_pc, if_inst);
    end
  endtask

  task automatic test_stall();
    do_reset();
    inst_ack = 1'b1; inst_rdata = 32'hA000_0000;
    cyc();
    stall = 1'b1;
    #1;
    checks++;
    if (inst_req !== 1'b0 || {if_valid, if_pc, if_inst} !== {1'b1, 32'h0, 32'hA000_0000}) begin
      failures++;
      $display("FAIL stall_idle got=%b slot=%b/%h/%h want=0 slot=1/00000000/a0000000",
               inst_req, if_valid, if_pc, if_inst);
    end
    cyc();
    stall = 1'b0;
    #1;
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h4) begin
      failures++; $display("FAIL stall_issue got=%b/%h want=1/00000004", inst_req, inst_addr);
    end
    cyc();
    stall = 1'b1;
    #1;
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h4 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_outst got=%b/%h/%b want=1/00000004/0", inst_req, inst_addr, if_valid);
    end
    cyc();
    inst_ack = 1'b1; inst_rdata = 32'hB000_0004;
    cyc();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (inst_req !== 1'b0 || {if_valid, if_pc, if_inst} !== 65'h0) begin
        failures++;
        $display("FAIL stall_frozen[%0d] got=%b slot=%b/%h/%h want=0 slot=0/0/0", i, inst_req,
                 if_valid, if_pc, if_inst);
      end
      cyc();
    end
    stall = 1'b0;
    #1;
    checks++;
    if (inst_req !== 1'b0 || if_valid !== 1'b0) begin
      failures++; $display("FAIL stall_release got=%b/%b want=0/0", inst_req, if_valid);
    end
    cyc();
    inst_ack = 1'b1; inst_rdata = 32'hC000_0008;
    #1;
    checks++;
    if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h4, 32'hB000_0004} || inst_addr !== 32'h8) begin
      failures++;
      $display("FAIL stall_skid got=%b/%h/%h addr=%h want=1/00000004/b0000004 addr=00000008",
               if_valid, if_pc, if_inst, inst_addr);
    end
    cyc();
    #1;
    checks++;
    if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h8, 32'hC000_0008}) begin
      failures++;
      $display("FAIL stall_next got=%b/%h/%h want=1/00000008/c0000008", if_valid, if_pc, if_inst);
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      inst_ack = 1'b1; inst_rdata = 32'(i * 4);
      cyc();
    end
    branch_flag = 1'b1; branch_target = 32'h100;
    #1;
    checks++;
    if ({if_valid, if_pc, if_inst} !== {1'b1, 32'hC, 32'hC} || inst_addr !== 32'h10) begin
      failures++;
      $display("FAIL br_delay_slot got=%b/%h/%h addr=%h want=1/0000000c/0000000c addr=00000010",
               if_valid, if_pc, if_inst, inst_addr);
    end
    cyc();
    #1;
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h10 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL br_drain got=%b/%h/%b want=1/00000010/0", inst_req, inst_addr, if_valid);
    end
    cyc();
    inst_ack = 1'b1; inst_rdata = 32'h10;
    cyc();
    #1;
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || inst_addr !== 32'h100 || inst_req !== 1'b1) begin
      failures++;
      $display("FAIL br_redirect got=%b/%h addr=%h want=0/00000000 addr=00000100",
               if_valid, if_pc, inst_addr);
    end
    inst_ack = 1'b1; inst_rdata = 32'h100;
    cyc();
    #1;
    checks++;
    if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h100, 32'h100}) begin
      failures++;
      $display("FAIL br_target got=%b/%h/%h want=1/00000100/00000100", if_valid, if_pc, if_inst);
    end
  endtask

  task automatic test_branch_stall();
    do_reset();
    inst_ack = 1'b1; inst_rdata = 32'h0;
    cyc();
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h200;
    #1;
    checks++;
    if (inst_req !== 1'b0) begin
      failures++; $display("FAIL brst_req got=%b want=0", inst_req);
    end
    cyc();
    stall = 1'b0;
    inst_ack = 1'b1; inst_rdata = 32'h4;
    #1;
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h4) begin
      failures++; $display("FAIL brst_seq got=%b/%h want=1/00000004", inst_req, inst_addr);
    end
    cyc();
    #1;
    checks++;
    if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h4, 32'h4}) begin
      failures++;
      $display("FAIL brst_slot got=%b/%h/%h want=1/00000004/00000004", if_valid, if_pc, if_inst);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      inst_ack = 1'b1; inst_rdata = 32'(i * 4);
      cyc();
    end
    #1;
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h40 || if_pc !== 32'h3C) begin
      failures++;
      $display("FAIL rmid_pre got=%b/%h pc=%h want=1/00000040 pc=0000003c", inst_req, inst_addr,
               if_pc);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (inst_req !== 1'b0 || inst_addr !== 32'h0 || {if_valid, if_pc, if_inst} !== 65'h0) begin
      failures++;
      $display("FAIL rmid_async got=%b/%h slot=%b/%h/%h want=0/00000000 slot=0/0/0", inst_req,
               inst_addr, if_valid, if_pc, if_inst);
    end
    cyc();
    cyc();
    rst = 1'b0;
    inst_ack = 1'b1; inst_rdata = 32'h0;
    #1;
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h0) begin
      failures++; $display("FAIL rmid_restart got=%b/%h want=1/00000000", inst_req, inst_addr);
    end
    cyc();
    #1;
    checks++;
    if ({if_valid, if_pc} !== {1'b1, 32'h0} || inst_addr !== 32'h4) begin
      failures++;
      $display("FAIL rmid_first got=%b/%h addr=%h want=1/00000000 addr=00000004", if_valid, if_pc,
               inst_addr);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_branch();
    test_branch_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
